// File: rtl/kogge_correction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : kogge_correction_sequencer
// Brief    : Feeds operands to the 16-bit fault-correcting Kogge-Stone unit,
//            steps its slice counter, captures and flags the corrected result.
// Revision : 1.0 - initial release
// ============================================================================
module kogge_correction_sequencer #(
  parameter int WIDTH       = 16,  // only 16 (4 slices x 4 bits) is meaningful
  parameter int SLICES      = 4,
  parameter int FAULT_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic                   in_cin,
  output logic                   u_rst,
  output logic [WIDTH-1:0]       u_a,
  output logic [WIDTH-1:0]       u_b,
  output logic                   u_cin,
  output logic                   u_correction_enable,
  input  logic [WIDTH-1:0]       u_corrected_sum,
  input  logic [WIDTH-1:0]       u_uncorrected_sum,
  input  logic                   u_cout,
  input  logic                   fault_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_sum,
  output logic                   out_cout,
  output logic                   out_fault,
  output logic [FAULT_CNT_W-1:0] fault_count,
  output logic                   busy
);

  localparam logic [2:0] c_ST_INIT    = 3'd0;
  localparam logic [2:0] c_ST_IDLE    = 3'd1;
  localparam logic [2:0] c_ST_RUN     = 3'd2;
  localparam logic [2:0] c_ST_CAPTURE = 3'd3;
  localparam logic [2:0] c_ST_HOLD    = 3'd4;

  localparam int                     c_CNT_W      = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [c_CNT_W-1:0]     c_LAST_SLICE = c_CNT_W'(SLICES - 1);
  localparam logic [FAULT_CNT_W-1:0] c_FAULT_MAX  = {FAULT_CNT_W{1'b1}};

  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic [c_CNT_W-1:0]     r_slice_cnt;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic                   r_cin;
  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_out_sum;
  logic                   r_out_cout;
  logic                   r_out_fault;
  logic [FAULT_CNT_W-1:0] r_fault_count;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_fault;

  assign w_accept  = in_valid & in_ready;
  assign w_capture = (r_state == c_ST_CAPTURE);
  assign w_fault   = (u_corrected_sum != u_uncorrected_sum);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_INIT:    w_state_nxt = c_ST_IDLE;
      c_ST_IDLE:    if (in_valid) w_state_nxt = c_ST_RUN;
      c_ST_RUN:     if (r_slice_cnt == c_LAST_SLICE) w_state_nxt = c_ST_CAPTURE;
      c_ST_CAPTURE: w_state_nxt = c_ST_HOLD;
      c_ST_HOLD:    if (out_ready) w_state_nxt = c_ST_IDLE;
      default:      w_state_nxt = c_ST_INIT;
    endcase
  end

  // Output decode; INIT is also the state held throughout reset
  always_comb begin
    u_rst               = 1'b0;
    in_ready            = 1'b0;
    u_correction_enable = 1'b0;
    busy                = 1'b1;
    case (r_state)
      c_ST_INIT: u_rst = 1'b1;
      c_ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      c_ST_RUN:  u_correction_enable = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand hold, slice count, result capture, fault counter.
  // Capture must happen on the CAPTURE edge: the next enable would start
  // rewriting slice 0 and replace cout with the slice-0 carry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a           <= '0;
      r_b           <= '0;
      r_cin         <= 1'b0;
      r_slice_cnt   <= '0;
      r_out_valid   <= 1'b0;
      r_out_sum     <= '0;
      r_out_cout    <= 1'b0;
      r_out_fault   <= 1'b0;
      r_fault_count <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= in_a;
        r_b   <= in_b;
        r_cin <= in_cin;
      end

      if (w_accept) begin
        r_slice_cnt <= '0;
      end else if (r_state == c_ST_RUN) begin
        r_slice_cnt <= r_slice_cnt + 1'b1;
      end

      if (w_capture) begin
        r_out_sum   <= u_corrected_sum;
        r_out_cout  <= u_cout;
        r_out_fault <= w_fault;
        r_out_valid <= 1'b1;
      end else if ((r_state == c_ST_HOLD) && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (fault_clr) begin
        r_fault_count <= '0;
      end else if (w_capture && w_fault && (r_fault_count != c_FAULT_MAX)) begin
        r_fault_count <= r_fault_count + 1'b1;
      end
    end
  end

  assign u_a         = r_a;
  assign u_b         = r_b;
  assign u_cin       = r_cin;
  assign out_valid   = r_out_valid;
  assign out_sum     = r_out_sum;
  assign out_cout    = r_out_cout;
  assign out_fault   = r_out_fault;
  assign fault_count = r_fault_count;

endmodule
`default_nettype wire

// File: tb/tb_kogge_correction_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_kogge_correction_sequencer
// Brief    : Bench with a behavioural slice-serial correction unit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kogge_correction_sequencer;

  localparam int FCW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [15:0]    in_a;
  logic [15:0]    in_b;
  logic           in_cin;
  logic           u_rst;
  logic [15:0]    u_a;
  logic [15:0]    u_b;
  logic           u_cin;
  logic           u_correction_enable;
  logic [15:0]    u_corrected_sum;
  logic [15:0]    u_uncorrected_sum;
  logic           u_cout;
  logic           fault_clr;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    out_sum;
  logic           out_cout;
  logic           out_fault;
  logic [FCW-1:0] fault_count;
  logic           busy;

  always #5 clk = ~clk;

  kogge_correction_sequencer #(
    .WIDTH(16), .SLICES(4), .FAULT_CNT_W(FCW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .u_rst(u_rst), .u_a(u_a), .u_b(u_b), .u_cin(u_cin),
    .u_correction_enable(u_correction_enable),
    .u_corrected_sum(u_corrected_sum), .u_uncorrected_sum(u_uncorrected_sum),
    .u_cout(u_cout), .fault_clr(fault_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_fault(out_fault),
    .fault_count(fault_count), .busy(busy)
  );

  // Unit model: one 4-bit slice of the true sum written per enable edge
  logic [1:0]  um_cnt;
  logic [15:0] um_sum;
  logic        um_cout;
  logic        inj;
  logic [16:0] um_full;

  function automatic logic slice_carry(input logic [15:0] a, input logic [15:0] b,
                                       input logic c, input int k);
    logic [16:0] m;
    logic [16:0] p;
    m = (17'd1 << (4 * k + 4)) - 17'd1;
    p = ({1'b0, a} & m) + ({1'b0, b} & m) + {16'd0, c};
    return p[4 * k + 4];
  endfunction

  assign um_full           = {1'b0, u_a} + {1'b0, u_b} + {16'd0, u_cin};
  assign u_uncorrected_sum = um_full[15:0] ^ (inj ? 16'h0020 : 16'h0000);
  assign u_corrected_sum   = um_sum;
  assign u_cout            = um_cout;

  always @(posedge clk) begin
    if (u_rst) begin
      um_cnt  <= 2'd0;
      um_sum  <= 16'd0;
      um_cout <= 1'b0;
    end else if (u_correction_enable) begin
      um_sum[int'(um_cnt) * 4 +: 4] <= um_full[int'(um_cnt) * 4 +: 4];
      um_cout <= slice_carry(u_a, u_b, u_cin, int'(um_cnt));
      um_cnt  <= um_cnt + 2'd1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " u_rst"}, u_rst, 1);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " enable"}, u_correction_enable, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_sum"}, out_sum, 0);
    check({tag, " out_cout"}, out_cout, 0);
    check({tag, " out_fault"}, out_fault, 0);
    check({tag, " fault_count"}, fault_count, 0);
    check({tag, " u_a"}, u_a, 0);
    check({tag, " u_b"}, u_b, 0);
    check({tag, " u_cin"}, u_cin, 0);
    check({tag, " busy"}, busy, 1);
  endtask

  // One full transaction; called on a negedge, returns on a negedge in IDLE
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic fault_inj, input int hold,
                        input logic clr_cap, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_fault, input int exp_cnt);
    int lat;
    int en_cnt;
    logic [15:0] held;
    for (int k = 0; k < 20 && in_ready !== 1'b1; k++) @(negedge clk);
    check({tag, " in_ready before accept"}, in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; inj = fault_inj;
    @(negedge clk);
    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'b0;
    lat = -1;
    en_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      fault_clr = 1'b0;
      if (out_valid === 1'b1) begin
        lat = k - 1;
        break;
      end
      if (u_correction_enable === 1'b1) en_cnt++;
      else if (clr_cap && en_cnt == 4) fault_clr = 1'b1;
      @(negedge clk);
    end
    fault_clr = 1'b0;
    check({tag, " latency edges"}, lat, 5);
    if (lat < 0) return;
    check({tag, " enable cycles"}, en_cnt, 4);
    check({tag, " out_sum"}, out_sum, exp_sum);
    check({tag, " out_cout"}, out_cout, exp_cout);
    check({tag, " out_fault"}, out_fault, exp_fault);
    check({tag, " fault_count"}, fault_count, exp_cnt);
    check({tag, " in_ready in hold"}, in_ready, 0);
    check({tag, " operands held"}, {u_cin, u_a, u_b}, {cin, a, b});
    held = out_sum;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_a = ~a; in_b = ~b;
      @(negedge clk);
      check({tag, " stall out_valid"}, out_valid, 1);
      check({tag, " stall out_sum"}, out_sum, held);
      check({tag, " stall in_ready"}, in_ready, 0);
      check({tag, " stall enable"}, u_correction_enable, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    inj = 1'b0;
    check({tag, " out_valid drop"}, out_valid, 0);
    check({tag, " back to idle"}, {busy, in_ready}, 2'b01);
    check({tag, " u_a kept"}, u_a, a);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        inj;
    int          hold;
    logic        clr;
    logic [15:0] sum;
    logic        cout;
    logic        fault;
    int          cnt;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [16:0] full;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        ri;
    int          model_cnt;

    vt[0] = '{16'h1111, 16'h1010, 1'b0, 1'b0, 0, 1'b0, 16'h2121, 1'b0, 1'b0, 0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
    vt[2] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 0, 1'b0, 16'h0001, 1'b1, 1'b0, 0};
    vt[3] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 3, 1'b0, 16'h1000, 1'b0, 1'b0, 0};
    vt[4] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 0, 1'b0, 16'h0008, 1'b0, 1'b1, 1};
    vt[5] = '{16'hABCD, 16'h1111, 1'b0, 1'b1, 1, 1'b0, 16'hBCDE, 1'b0, 1'b1, 2};
    vt[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 0, 1'b0, 16'h0000, 1'b1, 1'b1, 3};
    vt[7] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 1'b0, 16'h8000, 1'b0, 1'b1, 3};
    vt[8] = '{16'h1000, 16'h2000, 1'b0, 1'b1, 2, 1'b0, 16'h3000, 1'b0, 1'b1, 3};
    vt[9] = '{16'h0001, 16'h0001, 1'b0, 1'b1, 0, 1'b1, 16'h0002, 1'b0, 1'b1, 0};

    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    fault_clr = 1'b0; out_ready = 1'b0; inj = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    #1;
    check("init u_rst after release", u_rst, 1);
    @(negedge clk);
    check("init u_rst one cycle", u_rst, 0);
    check("idle in_ready", in_ready, 1);
    check("idle busy", busy, 0);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].inj,
             vt[i].hold, vt[i].clr, vt[i].sum, vt[i].cout, vt[i].fault, vt[i].cnt);
    end

    model_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      ri = ($urandom_range(0, 3) == 0);
      full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      if (ri && model_cnt < (1 << FCW) - 1) model_cnt++;
      run_op($sformatf("rand%0d", i), ra, rb, rc, ri, int'($urandom_range(0, 2)),
             1'b0, full[15:0], full[16], ri, model_cnt);
    end

    // Abort an operation two slices in with an asynchronous reset
    for (int k = 0; k < 20 && in_ready !== 1'b1; k++) @(negedge clk);
    in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun enable before reset", u_correction_enable, 1);
    rst = 1'b0;
    #1;
    check_reset_values("midrun reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun u_rst after release", u_rst, 1);
    @(negedge clk);
    check("midrun u_rst one cycle", u_rst, 0);
    run_op("post reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
